// File: rtl/mux_2_1_if.sv
// mux_2_1_if: data, select and result bundle for one mux_2_1 leaf cell.
`timescale 1ns/10ps
interface mux_2_1_if #(parameter int WIDTH = 64);
  logic [WIDTH-1:0] i0, i1, out, out_q;
  logic sel;
  modport master (output i0, i1, sel, input out, out_q);
  modport slave (input i0, i1, sel, output out, out_q);
endinterface

// File: rtl/mux_2_1.sv
// mux_2_1: gate-level 2:1 word mux, combinational out plus registered out_q.
// Define MUX_2_1_GATE_DELAY_EN to give every gate and the register a 50 ps delay.
`timescale 1ns/10ps
`ifdef MUX_2_1_GATE_DELAY_EN
`define MUX_2_1_DLY #0.05
`else
`define MUX_2_1_DLY
`endif
module mux_2_1 #(parameter int WIDTH = 64) (
  input logic clk,
  input logic reset_n,
  mux_2_1_if.slave bus
);
  logic [WIDTH-1:0] i0, i1, a, b, out_d, out_q;
  logic sel, nsel;
  assign i0 = bus.i0;
  assign i1 = bus.i1;
  assign sel = bus.sel;
  not `MUX_2_1_DLY u_inv (nsel, sel);
  for (genvar k = 0; k < WIDTH; k++) begin : g_bit
    and `MUX_2_1_DLY u_a (a[k], i0[k], nsel);
    and `MUX_2_1_DLY u_b (b[k], i1[k], sel);
    or `MUX_2_1_DLY u_o (out_d[k], a[k], b[k]);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) out_q <= '0;
    else out_q <= `MUX_2_1_DLY out_d;
  assign bus.out = out_d;
  assign bus.out_q = out_q;
endmodule

// File: tb/tb_mux_2_1.sv
// tb_mux_2_1: directed test-plan checks, a 4:1 cascade and a randomized run against a reference model.
`timescale 1ns/10ps
module tb_mux_2_1;
  localparam logic [63:0] ONES = '1;
  logic clk = 0;
  logic reset_n = 0;
  logic [1:0] csel = 0;
  int vectors = 0;
  int miscompares = 0;
  bit run = 0;
  logic [63:0] mq = '0;
  always #5 clk = ~clk;
  mux_2_1_if #(.WIDTH(64)) m ();
  mux_2_1_if #(.WIDTH(64)) c0 ();
  mux_2_1_if #(.WIDTH(64)) c1 ();
  mux_2_1_if #(.WIDTH(64)) c2 ();
  mux_2_1 #(.WIDTH(64)) dut (.clk(clk), .reset_n(reset_n), .bus(m));
  mux_2_1 #(.WIDTH(64)) u_c0 (.clk(clk), .reset_n(reset_n), .bus(c0));
  mux_2_1 #(.WIDTH(64)) u_c1 (.clk(clk), .reset_n(reset_n), .bus(c1));
  mux_2_1 #(.WIDTH(64)) u_c2 (.clk(clk), .reset_n(reset_n), .bus(c2));
  assign c0.i0 = 64'd64357;
  assign c0.i1 = 64'd26000;
  assign c1.i0 = 64'd256;
  assign c1.i1 = 64'd128;
  assign c0.sel = csel[0];
  assign c1.sel = csel[0];
  assign c2.i0 = c0.out;
  assign c2.i1 = c1.out;
  assign c2.sel = csel[1];
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h @%0t", name, act, exp, $time);
    end
  endtask
  task automatic drive(logic [63:0] a, logic [63:0] b, logic s);
    @(negedge clk);
    #2;
    m.i0 = a;
    m.i1 = b;
    m.sel = s;
  endtask
  // Reference: out is the selected word; out_q is that word as it stood at the last edge, zero under reset.
  always @(posedge clk or negedge reset_n)
    mq = reset_n ? (m.sel ? m.i1 : m.i0) : '0;
  always @(negedge clk)
    if (run) begin
      chk("model_out", m.out, m.sel ? m.i1 : m.i0);
      chk("model_out_q", m.out_q, mq);
    end
  initial begin
    m.i0 = 64'h1234;
    m.i1 = 64'd5;
    m.sel = 0;
    #3;
    chk("reset_out_q", m.out_q, 64'd0);
    chk("reset_out_comb", m.out, 64'h1234);
    run = 1;
    @(negedge clk);
    #2 reset_n = 1;
    drive(64'd64357, 64'd26000, 0);
    #10 chk("sel0_i0", m.out, 64'd64357);
    drive(64'd64357, 64'd26000, 1);
    #10 chk("sel1_i1", m.out, 64'd26000);
    drive(ONES, 64'd0, 0);
    #10 chk("ones_sel0", m.out, ONES);
    drive(ONES, 64'd0, 1);
    #10 chk("zeros_sel1", m.out, 64'd0);
    drive(ONES, 64'd0, 0);
    #10 chk("ones_again", m.out, ONES);
    drive(64'd256, 64'd128, 1);
    #1;
    chk("lat_out", m.out, 64'd128);
    chk("lat_out_q_old", m.out_q, ONES);
    @(posedge clk);
    #1 chk("lat_out_q_new", m.out_q, 64'd128);
    #2 reset_n = 0;
    #1;
    chk("async_rst_q", m.out_q, 64'd0);
    chk("async_rst_out", m.out, 64'd128);
    @(posedge clk);
    #1 chk("edge_in_rst", m.out_q, 64'd0);
    @(negedge clk);
    #2 reset_n = 1;
    #1 chk("released_no_edge", m.out_q, 64'd0);
    @(posedge clk);
    #1 chk("first_edge_after", m.out_q, 64'd128);
    begin
      logic [63:0] cexp [4] = '{64'd64357, 64'd26000, 64'd256, 64'd128};
      for (int i = 0; i < 4; i++) begin
        csel = 2'(i);
        #1 chk($sformatf("cascade_%0d", i), c2.out, cexp[i]);
      end
    end
`ifdef MUX_2_1_GATE_DELAY_EN
    drive(ONES, 64'd0, 0);
    @(negedge clk);
    #2 m.sel = 1;
    #0.09;
    vectors++;
    if (m.out === 64'd0) begin
      miscompares++;
      $display("FAIL early_settle: got %h want not %h", m.out, 64'd0);
    end
    #0.07 chk("settled_150ps", m.out, 64'd0);
`endif
    for (int n = 0; n < 400; n++) begin
      drive({$urandom, $urandom}, ($urandom_range(0, 7) == 0) ? m.i0 : {$urandom, $urandom}, 1'($urandom));
      reset_n = ($urandom_range(0, 15) != 0);
    end
    drive(m.i0, m.i1, m.sel);
    reset_n = 1;
    repeat (2) @(negedge clk);
    run = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end
endmodule
